// File: rtl/execute_stage.sv
// Execute stage of the LC-3 pipeline: ALU, address generation and control
// fields registered for the memory-access and writeback stages.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [2:0]  NZP,
    output logic [2:0]  dr,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] M_Data,
    output logic [15:0] IR_Exec
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    logic [3:0]    opcode;
    logic [DW-1:0] sext9;
    logic [DW-1:0] sext6;
    logic [DW-1:0] sext5;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] pc_rel;
    logic [DW-1:0] base_off;
    logic [AW-1:0] ir_dr;

    logic [DW-1:0] aluout_nxt;
    logic [DW-1:0] pcout_nxt;
    logic [AW-1:0] nzp_nxt;
    logic [AW-1:0] dr_nxt;
    logic [1:0]    wctl_nxt;
    logic          mctl_nxt;
    logic [DW-1:0] mdata_nxt;

    assign opcode   = IR[15:12];
    assign ir_dr    = IR[11:9];
    assign sext9    = {{(DW-9){IR[8]}}, IR[8:0]};
    assign sext6    = {{(DW-6){IR[5]}}, IR[5:0]};
    assign sext5    = {{(DW-5){IR[4]}}, IR[4:0]};
    assign alu_b    = IR[5] ? sext5 : VSR2;
    assign pc_rel   = npc_in + sext9;
    assign base_off = VSR1 + sext6;

    // Register-file read addresses; stores read their source register through sr2
    assign sr1 = IR[8:6];
    assign sr2 = (opcode == OP_ST || opcode == OP_STR || opcode == OP_STI) ? IR[11:9] : IR[2:0];

    // Per-opcode result selection; anything not driven by an opcode stays 0
    always_comb begin
        aluout_nxt = '0;
        pcout_nxt  = '0;
        nzp_nxt    = '0;
        dr_nxt     = '0;
        wctl_nxt   = WB_ALU;
        mctl_nxt   = 1'b0;
        mdata_nxt  = '0;
        case (opcode)
            OP_ADD: begin
                aluout_nxt = VSR1 + alu_b;
                dr_nxt     = ir_dr;
            end
            OP_AND: begin
                aluout_nxt = VSR1 & alu_b;
                dr_nxt     = ir_dr;
            end
            OP_NOT: begin
                aluout_nxt = ~VSR1;
                dr_nxt     = ir_dr;
            end
            OP_BR: begin
                pcout_nxt = pc_rel;
                nzp_nxt   = ir_dr;
            end
            OP_JMP: begin
                pcout_nxt = VSR1;
                nzp_nxt   = 3'b111;
            end
            OP_LD, OP_LDI: begin
                aluout_nxt = pc_rel;
                pcout_nxt  = pc_rel;
                dr_nxt     = ir_dr;
                wctl_nxt   = WB_MEM;
                mctl_nxt   = (opcode == OP_LDI);
            end
            OP_LDR: begin
                aluout_nxt = base_off;
                dr_nxt     = ir_dr;
                wctl_nxt   = WB_MEM;
            end
            OP_LEA: begin
                aluout_nxt = pc_rel;
                pcout_nxt  = pc_rel;
                dr_nxt     = ir_dr;
                wctl_nxt   = WB_PC;
            end
            OP_ST, OP_STI: begin
                aluout_nxt = pc_rel;
                mdata_nxt  = VSR2;
                mctl_nxt   = (opcode == OP_STI);
            end
            OP_STR: begin
                aluout_nxt = base_off;
                mdata_nxt  = VSR2;
            end
            default: ;
        endcase
    end

    // Pipeline register, advanced only when the controller enables this stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aluout          <= '0;
            pcout           <= '0;
            NZP             <= '0;
            dr              <= '0;
            W_Control_out   <= '0;
            Mem_Control_out <= 1'b0;
            M_Data          <= '0;
            IR_Exec         <= '0;
        end else if (enable_execute) begin
            aluout          <= aluout_nxt;
            pcout           <= pcout_nxt;
            NZP             <= nzp_nxt;
            dr              <= dr_nxt;
            W_Control_out   <= wctl_nxt;
            Mem_Control_out <= mctl_nxt;
            M_Data          <= mdata_nxt;
            IR_Exec         <= IR;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [2:0]  nzp;
        logic [2:0]  dr;
        logic [1:0]  wc;
        logic        mc;
        logic [15:0] md;
        logic [15:0] ir;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_execute;
    logic [15:0] IR, npc_in, VSR1, VSR2;
    logic [2:0]  sr1, sr2;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [2:0]  NZP, dr;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;

    exp_t obs;
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign obs = {aluout, pcout, NZP, dr, W_Control_out, Mem_Control_out, M_Data, IR_Exec};

    always #5 clock = ~clock;

    execute_stage dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .IR(IR), .npc_in(npc_in), .VSR1(VSR1), .VSR2(VSR2),
        .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .NZP(NZP), .dr(dr),
        .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
        .M_Data(M_Data), .IR_Exec(IR_Exec)
    );

    // Sign-extend the low n bits of x as a plain integer
    function automatic int sx(input int x, input int n);
        int v;
        v = x % (1 << n);
        if (v >= (1 << (n - 1))) v = v - (1 << n);
        return v;
    endfunction

    // Expected registered outputs for one instruction, from the ISA rules
    function automatic exp_t model(input logic [15:0] ir, input logic [15:0] npc,
                                   input logic [15:0] v1, input logic [15:0] v2);
        exp_t e;
        int op, a, b, s9, s6, s5, d, pcrel;
        e   = '0;
        op  = int'(ir) / 4096;
        a   = int'(v1);
        b   = int'(v2);
        d   = (int'(ir) / 512) % 8;
        s9  = sx(int'(ir), 9);
        s6  = sx(int'(ir), 6);
        s5  = sx(int'(ir), 5);
        pcrel = (int'(npc) + s9) & 65535;
        e.ir = ir;
        case (op)
            1:  begin e.alu = 16'((a + (ir[5] ? s5 : b)) & 65535); e.dr = 3'(d); end
            5:  begin e.alu = 16'((a & (ir[5] ? s5 : b)) & 65535); e.dr = 3'(d); end
            9:  begin e.alu = 16'(65535 - a); e.dr = 3'(d); end
            0:  begin e.pc = 16'(pcrel); e.nzp = 3'(d); end
            12: begin e.pc = v1; e.nzp = 3'd7; end
            2, 10: begin
                e.alu = 16'(pcrel); e.pc = 16'(pcrel); e.dr = 3'(d);
                e.wc = 2'd1; e.mc = (op == 10);
            end
            6:  begin e.alu = 16'((a + s6) & 65535); e.dr = 3'(d); e.wc = 2'd1; end
            14: begin e.alu = 16'(pcrel); e.pc = 16'(pcrel); e.dr = 3'(d); e.wc = 2'd2; end
            3, 11: begin e.alu = 16'(pcrel); e.md = v2; e.mc = (op == 11); end
            7:  begin e.alu = 16'((a + s6) & 65535); e.md = v2; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [15:0] ir, input logic [15:0] npc,
                         input logic [15:0] v1, input logic [15:0] v2, input logic en);
        IR = ir; npc_in = npc; VSR1 = v1; VSR2 = v2; enable_execute = en;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(16'h1283, 16'h3000, 16'h1111, 16'h2222, 1'b1);
        step();
        step();
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs);
        end
        #2 reset = 1'b0;
        step();
        cur = model(16'h1283, 16'h3000, 16'h1111, 16'h2222);
    endtask

    task automatic test_add();
        drive(16'h1283, 16'h0000, 16'h0005, 16'h0007, 1'b1);
        #1;
        n_tests++;
        if (sr1 !== 3'd2 || sr2 !== 3'd3) begin
            n_fail++;
            $display("FAIL add_reg_addr: got sr1=%0d sr2=%0d want 2 3", sr1, sr2);
        end
        step();
        n_tests++;
        if (aluout !== 16'h000C || dr !== 3'd1 || W_Control_out !== 2'd0 || obs !== model(IR, npc_in, VSR1, VSR2)) begin
            n_fail++;
            $display("FAIL add_reg: got %h want alu=000C dr=1 wc=0", obs);
        end
        drive(16'h12BF, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        step();
        n_tests++;
        if (aluout !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL add_imm_wrap0: got %h want FFFF", aluout);
        end
        drive(16'h12BF, 16'h0000, 16'h8000, 16'h0000, 1'b1);
        step();
        n_tests++;
        if (aluout !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL add_imm_wrap8000: got %h want 7FFF", aluout);
        end
        cur = obs;
    endtask

    task automatic test_branch();
        drive(16'h0BFE, 16'h3001, 16'h1234, 16'h5678, 1'b1);
        step();
        n_tests++;
        if (pcout !== 16'h2FFF || NZP !== 3'b101 || aluout !== 16'h0 || dr !== 3'd0) begin
            n_fail++;
            $display("FAIL br: got pc=%h nzp=%b alu=%h dr=%0d want 2FFF 101 0000 0", pcout, NZP, aluout, dr);
        end
        cur = obs;
    endtask

    task automatic test_store();
        drive(16'h7642, 16'h3000, 16'h4000, 16'hBEEF, 1'b1);
        #1;
        n_tests++;
        if (sr2 !== 3'd3) begin
            n_fail++;
            $display("FAIL str_sr2: got %0d want 3", sr2);
        end
        step();
        n_tests++;
        if (aluout !== 16'h4002 || M_Data !== 16'hBEEF || Mem_Control_out !== 1'b0) begin
            n_fail++;
            $display("FAIL str: got alu=%h md=%h mc=%b want 4002 BEEF 0", aluout, M_Data, Mem_Control_out);
        end
        drive(16'hB642, 16'h3000, 16'h4000, 16'hBEEF, 1'b1);
        step();
        n_tests++;
        if (Mem_Control_out !== 1'b1 || aluout !== 16'h3042 || M_Data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL sti: got alu=%h md=%h mc=%b want 3042 BEEF 1", aluout, M_Data, Mem_Control_out);
        end
        cur = obs;
    endtask

    task automatic test_hold();
        exp_t held;
        drive(16'h1283, 16'h0000, 16'h0005, 16'h0007, 1'b1);
        step();
        held = model(16'h1283, 16'h0000, 16'h0005, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            step();
            n_tests++;
            if (obs !== held) begin
                n_fail++;
                $display("FAIL hold_%0d: got %h want %h", i, obs, held);
            end
        end
        drive(16'h5283, 16'h0000, 16'h00F5, 16'h0F0F, 1'b1);
        step();
        n_tests++;
        if (aluout !== 16'h0005 || IR_Exec !== 16'h5283) begin
            n_fail++;
            $display("FAIL hold_reenable: got alu=%h ir=%h want 0005 5283", aluout, IR_Exec);
        end
        cur = obs;
    endtask

    task automatic test_reset_mid();
        drive(16'hE3FF, 16'h4000, 16'h0000, 16'h0000, 1'b1);
        step();
        n_tests++;
        if (aluout !== 16'h3FFF || pcout !== 16'h3FFF || W_Control_out !== 2'd2 || dr !== 3'd1) begin
            n_fail++;
            $display("FAIL lea: got alu=%h pc=%h wc=%0d dr=%0d want 3FFF 3FFF 2 1", aluout, pcout, W_Control_out, dr);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        drive(16'h1283, 16'h0000, 16'h0005, 16'h0007, 1'b1);
        step();
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_wins_edge: got %h want 0", obs);
        end
        reset = 1'b0;
        drive(16'hD000, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b1);
        step();
        n_tests++;
        if (obs !== {73'h0} + 73'(16'hD000)) begin
            n_fail++;
            $display("FAIL nop_after_reset: got %h want only IR_Exec=D000", obs);
        end
        cur = obs;
    endtask

    task automatic test_random();
        exp_t    nxt;
        logic [15:0] ir;
        logic        en;
        int          op;
        logic [2:0]  want_sr2;
        for (int i = 0; i < 300; i++) begin
            ir = 16'($urandom);
            en = ($urandom_range(0, 4) != 0);
            drive(ir, 16'($urandom), 16'($urandom), 16'($urandom), en);
            #1;
            op = int'(ir) / 4096;
            want_sr2 = (op == 3 || op == 7 || op == 11) ? 3'((int'(ir) / 512) % 8) : 3'(int'(ir) % 8);
            n_tests++;
            if (sr1 !== 3'((int'(ir) / 64) % 8) || sr2 !== want_sr2) begin
                n_fail++;
                $display("FAIL rand_addr_%0d: ir=%h got sr1=%0d sr2=%0d want sr2=%0d", i, ir, sr1, sr2, want_sr2);
            end
            nxt = en ? model(IR, npc_in, VSR1, VSR2) : cur;
            step();
            n_tests++;
            if (obs !== nxt) begin
                n_fail++;
                $display("FAIL rand_%0d: ir=%h en=%b got %h want %h", i, ir, en, obs, nxt);
            end
            cur = nxt;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops [6] = '{16'h2A05, 16'hAA05, 16'h6A7F, 16'h9A3F, 16'hC1C0, 16'h3E10};
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], 16'h0100 + 16'(i), 16'h8001, 16'h00AA, 1'b1);
            step();
            n_tests++;
            if (obs !== model(ops[i], 16'h0100 + 16'(i), 16'h8001, 16'h00AA)) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h want %h", i, obs, model(ops[i], 16'h0100 + 16'(i), 16'h8001, 16'h00AA));
            end
        end
    endtask

    initial begin
        cur = '0;
        test_reset();
        test_add();
        test_branch();
        test_store();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage LC-3 pipeline, directly upstream of the writeback stage. It drives the writeback stage's register-read addresses (`sr1`, `sr2`) and consumes the `VSR1`/`VSR2` operands that stage returns. It registers the ALU result, the branch/jump target and the control fields for the memory-access and writeback stages. All datapath results have a one-cycle latency, gated by `enable_execute`.

## Interface
- No parameters. Data width is fixed at 16 bits; register address width is fixed at 3 bits.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable_execute`  in  1  pipeline advance. Registered outputs load only when this is 1.
- `IR`  in  16  instruction from decode.
- `npc_in`  in  16  PC+1 of `IR`.
- `VSR1`  in  16  register-file read data for `sr1`, from writeback.
- `VSR2`  in  16  register-file read data for `sr2`, from writeback.
- `sr1`  out  3  combinational read address: `IR[8:6]`.
- `sr2`  out  3  combinational read address:
  - `IR[11:9]` for ST/STR/STI.
  - `IR[2:0]` otherwise.
- `aluout`  out  16  registered ALU result or effective address.
- `pcout`  out  16  registered PC-relative target.
- `NZP`  out  3  registered branch condition mask.
- `dr`  out  3  registered destination register.
- `W_Control_out`  out  2  registered writeback source: 0 = ALU, 1 = memory, 2 = pcout.
- `Mem_Control_out`  out  1  registered indirect-access flag.
- `M_Data`  out  16  registered store data.
- `IR_Exec`  out  16  registered copy of `IR`.

## Operation
Definitions:
- `sext9 = sext(IR[8:0])`, `sext6 = sext(IR[5:0])`, `sext5 = sext(IR[4:0])`.
- All additions are modulo 2^16. Carry and overflow are discarded.

Result per opcode (`IR[15:12]`); values are loaded on a clock edge with `enable_execute`=1:
- ADD (0001):
  - `aluout = VSR1 + (IR[5] ? sext5 : VSR2)`.
  - `dr = IR[11:9]`, `W_Control_out = 0`.
- AND (0101):
  - `aluout = VSR1 & (IR[5] ? sext5 : VSR2)`.
  - `dr = IR[11:9]`, `W_Control_out = 0`.
- NOT (1001):
  - `aluout = ~VSR1`.
  - `dr = IR[11:9]`, `W_Control_out = 0`.
- BR (0000): `pcout = npc_in + sext9`, `NZP = IR[11:9]`.
- JMP (1100): `pcout = VSR1`, `NZP = 3'b111`.
- LD (0010) / LDI (1010):
  - `aluout = pcout = npc_in + sext9`.
  - `dr = IR[11:9]`, `W_Control_out = 1`.
  - `Mem_Control_out = 1` for LDI only.
- LDR (0110):
  - `aluout = VSR1 + sext6`.
  - `dr = IR[11:9]`, `W_Control_out = 1`.
- LEA (1110):
  - `aluout = pcout = npc_in + sext9`.
  - `dr = IR[11:9]`, `W_Control_out = 2`.
- ST (0011) / STI (1011):
  - `aluout = npc_in + sext9`, `M_Data = VSR2`.
  - `Mem_Control_out = 1` for STI only.
- STR (0111): `aluout = VSR1 + sext6`, `M_Data = VSR2`.

Default rule:
- Any field not listed for an opcode loads 0.
- The fields covered by this rule are `aluout`, `pcout`, `NZP`, `dr`, `W_Control_out`, `Mem_Control_out` and `M_Data`.

Unused opcodes (1000, 1101, 0100, 1111) are a NOP: every field above loads 0.

`IR_Exec` loads `IR` on every enabled edge, whatever the opcode.

## Timing
- Reset: while `reset`=1, all registered outputs are 0 immediately (asynchronous), including `IR_Exec`=16'h0000.
- Reset mid-operation: clears all registered outputs at once; the in-flight instruction is lost. The first enabled edge after `reset` deasserts loads normally.
- Latency: registered outputs reflect the `IR`, `npc_in`, `VSR1` and `VSR2` present at an enabled rising edge. They are valid from that edge until the next enabled edge.
- Hold: with `enable_execute`=0, every registered output holds its value indefinitely.
- Combinational read path: `sr1`/`sr2` follow `IR` combinationally. Writeback returns `VSR1`/`VSR2` within the same cycle, so both are sampled on the same edge as `IR`.
- Simultaneous `reset` and enabled edge: reset wins and outputs stay 0.
- No forwarding or stall generation inside this block; hazards are the controller's responsibility.

## Test plan
- ADD register: IR=16'h1283 (R1=R2+R3), VSR1=16'h0005, VSR2=16'h0007, enable=1 → one cycle later `aluout`=16'h000C, `dr`=1, `W_Control_out`=0, `sr1`=2, `sr2`=3.
- ADD immediate with wrap: IR=16'h12BF (R1=R2+(-1)), VSR1=16'h0000 → `aluout`=16'hFFFF. Repeat with VSR1=16'h8000 → `aluout`=16'h7FFF.
- BR: IR=16'h0BFE (BRnp, offset -2), npc_in=16'h3001 → `pcout`=16'h2FFF, `NZP`=3'b101, `aluout`=0, `dr`=0.
- STR/STI:
  - STR: IR=16'h7642 (STR R3,R1,#2), VSR1=16'h4000, VSR2=16'hBEEF → `sr2`=3, `aluout`=16'h4002, `M_Data`=16'hBEEF, `Mem_Control_out`=0.
  - STI: same operands with opcode 1011 → `Mem_Control_out`=1.
- Enable hold: load ADD result 16'h000C, then drop `enable_execute` for 5 cycles while changing IR/VSR1/VSR2 → all outputs stay unchanged. Re-enable → the new result appears after one edge.
- Reset mid-operation: assert `reset` between clock edges after a LEA load → all outputs are 0 before the next edge. Deassert `reset` and issue a NOP opcode 16'hD000 → all outputs 0 except `IR_Exec`=16'hD000.
